// File: rtl/sll_serial_if.sv
// Handshake and data bundle for the serial logical left shifter.
//   start     : request pulse, sampled only while the shifter is idle
//   A         : operand, captured on the accepting edge
//   Shamt     : shift amount, captured on the accepting edge
//   ShiftedLL : working/result register
//   busy      : high while a shift is in progress or its result is being presented
//   done      : one-cycle pulse; ShiftedLL, carry_out and zero are valid
//   carry_out : last bit shifted out of the top bit
//   zero      : result equals zero (valid with done)
interface sll_serial_if #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned SHAMT_W = 4
);
    logic               start;
    logic [WIDTH-1:0]   A;
    logic [SHAMT_W-1:0] Shamt;
    logic [WIDTH-1:0]   ShiftedLL;
    logic               busy;
    logic               done;
    logic               carry_out;
    logic               zero;

    modport master (
        output start, A, Shamt,
        input  ShiftedLL, busy, done, carry_out, zero
    );

    modport slave (
        input  start, A, Shamt,
        output ShiftedLL, busy, done, carry_out, zero
    );
endinterface

// File: rtl/sll_serial.sv
// Multi-cycle logical left shifter: shifts the captured operand left one bit per clock,
// reports the last bit shifted out of the top and a zero flag with a one-cycle done pulse.
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high
//   bus   : sll_serial_if slave modport (start/A/Shamt in; ShiftedLL/busy/done/
//           carry_out/zero out)
module sll_serial #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned SHAMT_W = 4
) (
    input  logic         clk,
    input  logic         reset,
    sll_serial_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   shifted_q, shifted_d;
    logic [SHAMT_W-1:0] count_q, count_d;
    logic               carry_q, carry_d;
    logic               zero_q, zero_d;
    logic               accept;

    assign accept = (state_q == StIdle) && bus.start;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = (bus.Shamt == '0) ? StDone : StShift;
                end
            end
            StShift: begin
                if (count_q == SHAMT_W'(1)) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        bus.busy = 1'b0;
        bus.done = 1'b0;
        unique case (state_q)
            StIdle:  ;
            StShift: bus.busy = 1'b1;
            StDone: begin
                bus.busy = 1'b1;
                bus.done = 1'b1;
            end
            default: ;
        endcase
    end

    // Datapath next-state
    always_comb begin
        shifted_d = shifted_q;
        count_d   = count_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        if (accept) begin
            shifted_d = bus.A;
            count_d   = bus.Shamt;
            carry_d   = 1'b0;
            zero_d    = 1'b0;
        end else if (state_q == StShift) begin
            shifted_d = {shifted_q[WIDTH-2:0], 1'b0};
            carry_d   = shifted_q[WIDTH-1];
            count_d   = SHAMT_W'(count_q - 1'b1);
        end
        // Zero flag is latched from the final value on the edge that enters DONE,
        // so it holds together with the result until the next accepted start.
        if ((state_d == StDone) && (state_q != StDone)) begin
            zero_d = (shifted_d == '0);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shifted_q <= '0;
            count_q   <= '0;
            carry_q   <= 1'b0;
            zero_q    <= 1'b0;
        end else begin
            shifted_q <= shifted_d;
            count_q   <= count_d;
            carry_q   <= carry_d;
            zero_q    <= zero_d;
        end
    end

    assign bus.ShiftedLL = shifted_q;
    assign bus.carry_out = carry_q;
    assign bus.zero      = zero_q;

endmodule

// File: tb/tb_sll_serial.sv
module tb_sll_serial;

    typedef struct packed {
        logic [15:0] res;
        logic        cy;
        logic        z;
    } exp_t;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_err;
    exp_t sb[$];
    logic prev_done;

    sll_serial_if #(.WIDTH(16), .SHAMT_W(4)) bus_if ();

    sll_serial #(.WIDTH(16), .SHAMT_W(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [15:0] a, input logic [3:0] sh);
        logic [31:0] wide;
        exp_t e;
        wide  = {16'h0, a} << sh;
        e.res = wide[15:0];
        e.cy  = wide[16];
        e.z   = (wide[15:0] == 16'h0);
        return e;
    endfunction

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_res"},  {16'h0, bus_if.ShiftedLL}, 32'h0);
        check_eq({tag, "_busy"}, {31'h0, bus_if.busy}, 32'h0);
        check_eq({tag, "_done"}, {31'h0, bus_if.done}, 32'h0);
        check_eq({tag, "_cy"},   {31'h0, bus_if.carry_out}, 32'h0);
        check_eq({tag, "_zero"}, {31'h0, bus_if.zero}, 32'h0);
    endtask

    // Scoreboard monitor: every done pops one expected result
    always @(negedge clk) begin
        if (reset) begin
            prev_done = 1'b0;
        end else begin
            if (bus_if.done) begin
                check_eq("done_consecutive", {31'h0, prev_done}, 32'h0);
                if (sb.size() == 0) begin
                    check_eq("spurious_done", {31'h0, bus_if.done}, 32'h0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check_eq("result",    {16'h0, bus_if.ShiftedLL}, {16'h0, e.res});
                    check_eq("carry_out", {31'h0, bus_if.carry_out}, {31'h0, e.cy});
                    check_eq("zero",      {31'h0, bus_if.zero}, {31'h0, e.z});
                    check_eq("busy_done", {31'h0, bus_if.busy}, 32'h1);
                end
            end
            prev_done = bus_if.done;
        end
    end

    // One operation. hold: cycles start stays high after the capture cycle (ignored);
    // repulse_at / reset_at: cycle after capture for a new start / a reset (0 = none).
    task automatic run_op(input logic [15:0] a, input logic [3:0] sh, input int hold,
                          input int repulse_at, input int reset_at);
        exp_t e;
        int   lat;
        logic seen;
        e = model(a, sh);
        @(posedge clk);
        #1;
        bus_if.start = 1'b1;
        bus_if.A     = a;
        bus_if.Shamt = sh;
        sb.push_back(e);
        @(posedge clk);
        #1;
        lat  = 0;
        seen = 1'b0;
        for (int c = 1; c <= 40 && !seen; c++) begin
            bus_if.start = (c <= hold) || (c == repulse_at);
            if (c == repulse_at) begin
                bus_if.A     = 16'h0001;
                bus_if.Shamt = 4'd1;
            end
            if (c == reset_at) begin
                #2;
                reset = 1'b1;
                #1;
                check_all_zero("mid_reset");
                sb.delete();
                bus_if.start = 1'b0;
                repeat (2) @(posedge clk);
                #1;
                reset = 1'b0;
                repeat (20) @(posedge clk);
                #1;
                check_all_zero("post_reset");
                return;
            end
            @(negedge clk);
            if (bus_if.done) begin
                seen = 1'b1;
                lat  = c;
            end else begin
                check_eq("busy_while_shift", {31'h0, bus_if.busy}, 32'h1);
            end
            @(posedge clk);
            #1;
        end
        bus_if.start = 1'b0;
        check_eq("done_seen", {31'h0, seen}, 32'h1);
        check_eq("latency", lat, int'(sh) + 1);
        // Result and flags hold in IDLE
        @(negedge clk);
        check_eq("idle_busy", {31'h0, bus_if.busy}, 32'h0);
        check_eq("hold_res",  {16'h0, bus_if.ShiftedLL}, {16'h0, e.res});
        check_eq("hold_cy",   {31'h0, bus_if.carry_out}, {31'h0, e.cy});
        check_eq("hold_zero", {31'h0, bus_if.zero}, {31'h0, e.z});
        repeat (3) @(posedge clk);
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        prev_done    = 1'b0;
        reset        = 1'b1;
        bus_if.start = 1'b0;
        bus_if.A     = 16'h0;
        bus_if.Shamt = 4'd0;
        repeat (3) @(negedge clk);
        check_all_zero("in_reset");
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_all_zero("idle");
        end

        run_op(16'h0001, 4'd4, 0, 0, 0);
        run_op(16'h8001, 4'd1, 0, 0, 0);
        run_op(16'hABCD, 4'd0, 0, 0, 0);
        run_op(16'hABCD, 4'd0, 1, 0, 0);   // start also high during DONE
        run_op(16'h0002, 4'd15, 0, 0, 0);
        run_op(16'hFFFF, 4'd15, 0, 5, 0);  // re-pulse while busy is ignored
        run_op(16'hFFFF, 4'd15, 0, 5, 7);  // reset mid-shift, no done expected
        run_op(16'h1234, 4'd8, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            run_op(16'($urandom), 4'($urandom_range(0, 15)), 0, 0, 0);
        end
        check_eq("sb_empty", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
